// File: rtl/modexp_arb_pkg.sv
// rtl/modexp_arb_pkg.sv - shared types and constants for the modexp arbiter
package modexp_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    localparam int PERF_CNT_W = 16;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker
//   req_i       : request vector
//   ptr_i       : index with highest priority this round
//   grant_o     : one-hot winner
//   grant_idx_o : binary winner index
//   any_o       : at least one request present
module rr_picker #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] k;

    // Scan ptr, ptr+1, ... with wrap; the first set bit wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        sum         = '0;
        k           = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            k = sum[IW-1:0];
            if (!any_o && req_i[k]) begin
                any_o       = 1'b1;
                grant_o[k]  = 1'b1;
                grant_idx_o = k;
            end
        end
    end

endmodule

// File: rtl/modexp_arbiter.sv
// rtl/modexp_arbiter.sv - round-robin arbiter sharing one modexp engine
//   Optional feature macro: MODEXP_ARB_PERF_EN (adds done_count_out).
//   clk_in / rst_in            : clock, synchronous active-high reset
//   req_in, req_*_in           : per-requester request level and operands
//   ack_out                    : one-hot pulse, operands captured
//   result_out/_id_out/_valid  : engine result tagged with requester id
//   busy_out                   : operation in flight
//   eng_*_out / eng_*_in       : handshake and operands to/from the engine
//   done_count_out             : per-requester saturating completion counts
module modexp_arbiter
    import modexp_arb_pkg::*;
#(
    parameter int  WIDTH   = 16,
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [NUM_REQ-1:0]              req_in,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_value_in,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_exponent_in,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_modulus_in,
    output logic [NUM_REQ-1:0]              ack_out,
    output logic [WIDTH-1:0]                result_out,
    output logic [ID_W-1:0]                 result_id_out,
    output logic                            result_valid_out,
    output logic                            busy_out,
    output logic                            eng_ready_out,
    output logic [WIDTH-1:0]                eng_value_out,
    output logic [WIDTH-1:0]                eng_exponent_out,
    output logic [WIDTH-1:0]                eng_modulus_out,
    input  logic                            eng_busy_in,
    input  logic                            eng_valid_in,
    input  logic [WIDTH-1:0]                eng_value_in
`ifdef MODEXP_ARB_PERF_EN
    ,
    output logic [NUM_REQ-1:0][PERF_CNT_W-1:0] done_count_out
`endif
);

    arb_state_t          state_q;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     gid_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic                busy_q;
    logic                eng_ready_q;
    logic [WIDTH-1:0]    eng_value_q;
    logic [WIDTH-1:0]    eng_exponent_q;
    logic [WIDTH-1:0]    eng_modulus_q;
    logic [WIDTH-1:0]    result_q;
    logic [ID_W-1:0]     result_id_q;
    logic                result_valid_q;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic [ID_W-1:0]     rr_ptr_d;

    rr_picker #(.N(NUM_REQ)) u_picker (
        .req_i       (req_in),
        .ptr_i       (rr_ptr_q),
        .grant_o     (pick_grant),
        .grant_idx_o (pick_idx),
        .any_o       (pick_any)
    );

    // Priority moves to the requester just after the one served.
    assign rr_ptr_d = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= ARB_IDLE;
            rr_ptr_q       <= '0;
            gid_q          <= '0;
            ack_q          <= '0;
            busy_q         <= 1'b0;
            eng_ready_q    <= 1'b0;
            eng_value_q    <= '0;
            eng_exponent_q <= '0;
            eng_modulus_q  <= '0;
            result_q       <= '0;
            result_id_q    <= '0;
            result_valid_q <= 1'b0;
        end else begin
            ack_q          <= '0;
            eng_ready_q    <= 1'b0;
            result_valid_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any && !eng_busy_in) begin
                        ack_q          <= pick_grant;
                        eng_value_q    <= req_value_in[pick_idx];
                        eng_exponent_q <= req_exponent_in[pick_idx];
                        eng_modulus_q  <= req_modulus_in[pick_idx];
                        gid_q          <= pick_idx;
                        busy_q         <= 1'b1;
                        // Ready is registered so it is high exactly in ISSUE.
                        eng_ready_q    <= 1'b1;
                        state_q        <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    state_q <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    // Engine busy is not trusted here; only valid ends the run.
                    if (eng_valid_in) begin
                        result_q       <= eng_value_in;
                        result_id_q    <= gid_q;
                        result_valid_q <= 1'b1;
                        rr_ptr_q       <= rr_ptr_d;
                        busy_q         <= 1'b0;
                        state_q        <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign ack_out          = ack_q;
    assign result_out       = result_q;
    assign result_id_out    = result_id_q;
    assign result_valid_out = result_valid_q;
    assign busy_out         = busy_q;
    assign eng_ready_out    = eng_ready_q;
    assign eng_value_out    = eng_value_q;
    assign eng_exponent_out = eng_exponent_q;
    assign eng_modulus_out  = eng_modulus_q;

`ifdef MODEXP_ARB_PERF_EN
    logic [NUM_REQ-1:0][PERF_CNT_W-1:0] perf_cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_cnt_q <= '0;
        end else if (result_valid_q && (perf_cnt_q[result_id_q] != '1)) begin
            perf_cnt_q[result_id_q] <= perf_cnt_q[result_id_q] + 1'b1;
        end
    end

    assign done_count_out = perf_cnt_q;
`endif

endmodule

// File: tb/tb_modexp_arbiter.sv
// tb/tb_modexp_arbiter.sv - self-checking bench for modexp_arbiter with a stub engine
module tb_modexp_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int IW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N-1:0][W-1:0]  rv, re, rm;
    logic [N-1:0]         ack_out;
    logic [W-1:0]         result_out;
    logic [IW-1:0]        result_id_out;
    logic                 result_valid_out;
    logic                 busy_out;
    logic                 eng_ready_out;
    logic [W-1:0]         eng_value_out, eng_exponent_out, eng_modulus_out;
    logic                 eng_busy;
    logic                 stub_valid;
    logic                 spur_valid;
    logic                 eng_valid;
    logic [W-1:0]         eng_val;
`ifdef MODEXP_ARB_PERF_EN
    logic [N-1:0][15:0]   done_count_out;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign eng_valid = stub_valid | spur_valid;

    modexp_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .req_in           (req),
        .req_value_in     (rv),
        .req_exponent_in  (re),
        .req_modulus_in   (rm),
        .ack_out          (ack_out),
        .result_out       (result_out),
        .result_id_out    (result_id_out),
        .result_valid_out (result_valid_out),
        .busy_out         (busy_out),
        .eng_ready_out    (eng_ready_out),
        .eng_value_out    (eng_value_out),
        .eng_exponent_out (eng_exponent_out),
        .eng_modulus_out  (eng_modulus_out),
        .eng_busy_in      (eng_busy),
        .eng_valid_in     (eng_valid),
        .eng_value_in     (eng_val)
`ifdef MODEXP_ARB_PERF_EN
        ,
        .done_count_out   (done_count_out)
`endif
    );

    // Reference: square-and-multiply.
    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, e, m);
        longint unsigned r, x;
        logic [W-1:0] k;
        r = 64'(1) % 64'(m);
        x = 64'(b) % 64'(m);
        k = e;
        while (k != 0) begin
            if (k[0]) r = (r * x) % 64'(m);
            x = (x * x) % 64'(m);
            k = k >> 1;
        end
        return W'(r);
    endfunction

    // Stub engine arithmetic: naive repeated multiplication.
    function automatic logic [W-1:0] slow_modexp(input logic [W-1:0] b, e, m);
        longint unsigned r;
        r = 64'(1) % 64'(m);
        for (int i = 0; i < int'(e); i++) r = (r * 64'(b)) % 64'(m);
        return W'(r);
    endfunction

    // Stub engine with programmable latency.
    int       stub_lat;
    bit       stub_rand;
    int       stub_cnt;
    logic [W-1:0] cap_v, cap_e, cap_m;

    always @(posedge clk) begin
        if (rst) begin
            eng_busy   <= 1'b0;
            stub_valid <= 1'b0;
            stub_cnt   <= 0;
            eng_val    <= '0;
        end else begin
            stub_valid <= 1'b0;
            if (!eng_busy && eng_ready_out) begin
                cap_v    <= eng_value_out;
                cap_e    <= eng_exponent_out;
                cap_m    <= eng_modulus_out;
                eng_busy <= 1'b1;
                if (stub_rand) begin
                    case ($urandom_range(0, 2))
                        0:       stub_cnt <= 1;
                        1:       stub_cnt <= 5;
                        default: stub_cnt <= 40;
                    endcase
                end else begin
                    stub_cnt <= stub_lat;
                end
            end else if (eng_busy) begin
                if (stub_cnt <= 1) begin
                    stub_valid <= 1'b1;
                    eng_busy   <= 1'b0;
                    eng_val    <= slow_modexp(cap_v, cap_e, cap_m);
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int oh2idx(input logic [N-1:0] oh);
        for (int i = 0; i < N; i++) if (oh[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        req = '0;
        spur_valid = 1'b0;
        stub_rand = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_single(input int id, input logic [W-1:0] v, e, m, res);
        logic [N-1:0] oh;
        bit got;
        oh = '0;
        oh[id] = 1'b1;
        rv[id] = v; re[id] = e; rm[id] = m;
        req[id] = 1'b1;
        @(negedge clk);
        check("ack_latency", ack_out, oh);
        check("issue_ready", eng_ready_out, 1);
        check("busy_on_grant", busy_out, 1);
        check("eng_operands", {eng_value_out, eng_exponent_out, eng_modulus_out}, {v, e, m});
        req[id] = 1'b0;
        rv[id] = W'($urandom);
        re[id] = W'($urandom);
        got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (result_valid_out) got = 1;
        end
        check("result_seen", got, 1);
        if (got) begin
            check("result_value", result_out, res);
            check("result_id", result_id_out, id);
            check("busy_off_at_result", busy_out, 0);
            check("eng_operands_held", {eng_value_out, eng_exponent_out, eng_modulus_out}, {v, e, m});
            @(negedge clk);
            check("result_pulse_1cyc", result_valid_out, 0);
            check("result_held", result_out, res);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (!busy_out && !eng_busy) ok = 1;
        end
        check("drain", ok, 1);
    endtask

    logic [W-1:0] grp_res [4] = '{16'd24, 16'd445, 16'd1, 16'd5};

    task automatic run_group(input string tag);
        int ids[$];
        logic [W-1:0] res[$];
        rv[0] = 2; re[0] = 10; rm[0] = 1000;
        rv[1] = 4; re[1] = 13; rm[1] = 497;
        rv[2] = 5; re[2] = 0;  rm[2] = 13;
        rv[3] = 7; re[3] = 2;  rm[3] = 11;
        req = 4'hF;
        for (int n = 0; n < 600 && ids.size() < 4; n++) begin
            @(negedge clk);
            req = req & ~ack_out;
            if (result_valid_out) begin
                ids.push_back(int'(result_id_out));
                res.push_back(result_out);
            end
        end
        check({tag, "_count"}, ids.size(), 4);
        for (int k = 0; k < ids.size() && k < 4; k++) begin
            check({tag, "_id"}, ids[k], k);
            check({tag, "_value"}, res[k], grp_res[k]);
        end
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] v, e, m, res;
        int           lat;
    } vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t tbl [6];
        int t_ack[$];
        int id_ack[$];
        int cyc, nack0, nres, last_id;
        logic [W-1:0] last_res;
        logic [N-1:0] exp_ack;
        int rr, g, ndone;
        bit inflight, pend;
        int pend_id;
        logic [W-1:0] pend_res;

        tbl[0] = '{0, 16'd3, 16'd5,  16'd7,    16'd5,   1};
        tbl[1] = '{1, 16'd2, 16'd10, 16'd1000, 16'd24,  5};
        tbl[2] = '{2, 16'd4, 16'd13, 16'd497,  16'd445, 40};
        tbl[3] = '{3, 16'd5, 16'd0,  16'd13,   16'd1,   1};
        tbl[4] = '{3, 16'd7, 16'd2,  16'd11,   16'd5,   5};
        tbl[5] = '{2, 16'd3, 16'd5,  16'd7,    16'd5,   40};

        rst = 1'b1; req = '0; rv = '0; re = '0; rm = '0;
        spur_valid = 1'b0; stub_lat = 1; stub_rand = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ack", ack_out, 0);
        check("rst_result", {result_out, result_id_out, result_valid_out}, 0);
        check("rst_busy_ready", {busy_out, eng_ready_out}, 0);
        check("rst_eng_ops", {eng_value_out, eng_exponent_out, eng_modulus_out}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            stub_lat = tbl[i].lat;
            run_single(tbl[i].id, tbl[i].v, tbl[i].e, tbl[i].m, tbl[i].res);
        end

        // Four-way contention after reset, then again with wrapped pointer.
        do_reset();
        stub_lat = 5;
        run_group("group1");
        run_group("group2");

        // Two requesters held continuously must alternate with no idle gap.
        do_reset();
        stub_lat = 5;
        req = 4'b1010;
        cyc = 0;
        for (int n = 0; n < 200 && t_ack.size() < 6; n++) begin
            @(negedge clk);
            cyc++;
            if (ack_out != 0) begin
                t_ack.push_back(cyc);
                id_ack.push_back(oh2idx(ack_out));
            end
        end
        req = '0;
        check("alt_count", t_ack.size(), 6);
        for (int k = 0; k < t_ack.size(); k++) begin
            check("alt_id", id_ack[k], (k % 2 == 0) ? 1 : 3);
            if (k > 0) check("alt_gap", t_ack[k] - t_ack[k-1], 5 + 3);
        end
        drain();

        // Reset while the engine is running.
        do_reset();
        stub_lat = 40;
        rv[0] = 3; re[0] = 5; rm[0] = 7; req[0] = 1'b1;
        @(negedge clk);
        check("midrst_ack", ack_out, 4'b0001);
        req = '0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ack_zero", ack_out, 0);
        check("midrst_result_zero", {result_out, result_id_out, result_valid_out}, 0);
        check("midrst_busy_zero", {busy_out, eng_ready_out}, 0);
        check("midrst_ops_zero", {eng_value_out, eng_exponent_out, eng_modulus_out}, 0);
        nres = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (result_valid_out) nres++;
        end
        check("midrst_no_result", nres, 0);
        stub_lat = 5;
        run_single(2, 16'd3, 16'd5, 16'd7, 16'd5);

        // Withdrawn request is never served.
        do_reset();
        stub_lat = 20;
        rv[1] = 2; re[1] = 10; rm[1] = 1000; req[1] = 1'b1;
        @(negedge clk);
        check("wd_ack1", ack_out, 4'b0010);
        req[1] = 1'b0;
        rv[0] = 9; re[0] = 9; rm[0] = 9; req[0] = 1'b1;
        nack0 = 0; nres = 0; last_id = -1; last_res = '0;
        for (int n = 0; n < 65; n++) begin
            @(negedge clk);
            if (n == 4) req[0] = 1'b0;
            if (ack_out[0]) nack0++;
            if (result_valid_out) begin
                nres++;
                last_id = int'(result_id_out);
                last_res = result_out;
            end
        end
        check("wd_no_ack0", nack0, 0);
        check("wd_one_result", nres, 1);
        check("wd_id", last_id, 1);
        check("wd_value", last_res, 24);

        // Engine valid while idle is ignored.
        spur_valid = 1'b1;
        @(negedge clk);
        spur_valid = 1'b0;
        check("spurious_valid_ignored", {result_valid_out, busy_out}, 0);
        @(negedge clk);

        // Randomized traffic against a rule-level model.
        do_reset();
        stub_rand = 1'b1;
        rr = 0; inflight = 0; pend = 0; ndone = 0; pend_id = 0; pend_res = '0;
        for (int c = 0; c < 4400; c++) begin
            @(negedge clk);
            exp_ack = '0;
            if (!inflight) begin
                for (int k = 0; k < N; k++) begin
                    if (exp_ack == 0 && req[(rr + k) % N]) exp_ack[(rr + k) % N] = 1'b1;
                end
            end
            check("rand_ack", ack_out, exp_ack);
            if (exp_ack != 0) begin
                g = oh2idx(exp_ack);
                inflight = 1;
                pend = 1;
                pend_id = g;
                pend_res = ref_modexp(rv[g], re[g], rm[g]);
            end
            if (result_valid_out) begin
                check("rand_result_expected", pend, 1);
                check("rand_result_id", result_id_out, pend_id);
                check("rand_result_value", result_out, pend_res);
                inflight = 0;
                pend = 0;
                rr = (pend_id + 1) % N;
                ndone++;
            end
            check("rand_busy", busy_out, inflight);
            for (int i = 0; i < N; i++) begin
                if (c >= 4000) begin
                    req[i] = 1'b0;
                end else if (exp_ack[i]) begin
                    req[i] = 1'b0;
                    if ($urandom_range(0, 1) == 0) begin
                        rv[i] = W'($urandom_range(0, 65535));
                        re[i] = W'($urandom_range(0, 255));
                        rm[i] = W'($urandom_range(2, 65535));
                        req[i] = 1'b1;
                    end
                end else if (req[i]) begin
                    if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    rv[i] = W'($urandom_range(0, 65535));
                    re[i] = W'($urandom_range(0, 255));
                    rm[i] = W'($urandom_range(2, 65535));
                    req[i] = 1'b1;
                end
            end
        end
        check("rand_nothing_pending", pend, 0);
        check("rand_enough_ops", ndone > 20, 1);

`ifdef MODEXP_ARB_PERF_EN
        begin
            logic [N-1:0][15:0] pre;
            do_reset();
            stub_lat = 1;
            repeat (3) run_single(2, 16'd3, 16'd5, 16'd7, 16'd5);
            repeat (2) @(negedge clk);
            check("perf_cnt2", done_count_out[2], 3);
            check("perf_others", {done_count_out[3], done_count_out[1], done_count_out[0]}, 0);
            pre = '0;
            pre[2] = 16'hFFFE;
            force dut.perf_cnt_q = pre;
            @(negedge clk);
            release dut.perf_cnt_q;
            repeat (2) run_single(2, 16'd3, 16'd5, 16'd7, 16'd5);
            repeat (2) @(negedge clk);
            check("perf_saturate", done_count_out[2], 16'hFFFF);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
